regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardware clear sequence (one register per cycle).
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_reg_write,
  input  logic [AW-1:0]       i_addr_wr,
  input  logic [XLEN-1:0]     i_data_wr,
  input  logic [NRD*AW-1:0]   i_addr_rd,
  output logic [NRD*XLEN-1:0] o_data_rd,
  output logic                o_ready
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);

  state_t            state_r, state_nx_s;
  logic [AW:0]       cnt_r, cnt_nx_s;
  logic [XLEN-1:0]   mem_r [NREGS];
  logic              mem_we_s;
  logic [AW-1:0]     mem_wa_s;
  logic [XLEN-1:0]   mem_wd_s;
  logic              wr_ok_s;

  // An address is usable when it lies inside the array and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = (int'({1'b0, a}) < NREGS) && !((ZERO_REG != 0) && (a == {AW{1'b0}}));
  endfunction

  assign wr_ok_s = addr_ok(i_addr_wr);
  assign o_ready = (state_r == ST_IDLE);

  // State and clear-counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {(AW+1){1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state logic and the single storage write port (clear sweep or user write).
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    mem_we_s   = 1'b0;
    mem_wa_s   = {AW{1'b0}};
    mem_wd_s   = {XLEN{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        mem_wa_s = cnt_r[AW-1:0];
        if (i_clear) begin
          cnt_nx_s = {(AW+1){1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = {(AW+1){1'b0}};
        end else begin
          cnt_nx_s = cnt_r + {{AW{1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (i_clear) begin
          state_nx_s = ST_CLEAR;
          cnt_nx_s   = {(AW+1){1'b0}};
        end else if (i_reg_write && wr_ok_s) begin
          mem_we_s = 1'b1;
          mem_wa_s = i_addr_wr;
          mem_wd_s = i_data_wr;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_nx_s = ST_CLEAR;
        cnt_nx_s   = {(AW+1){1'b0}};
      end
    endcase
  end

  // Storage array; deliberately not reset, the clear sweep initialises it.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] rd_s;

    assign ra_s = i_addr_rd[k*AW +: AW];
    assign o_data_rd[k*XLEN +: XLEN] = rd_s;

    // Combinational read with zero forcing while clearing or on unusable addresses.
    always_comb begin
      rd_s = {XLEN{1'b0}};
      if (state_r != ST_IDLE) begin
        rd_s = {XLEN{1'b0}};
      end else if (!addr_ok(ra_s)) begin
        rd_s = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (i_reg_write && wr_ok_s && (ra_s == i_addr_wr)) begin
        rd_s = i_data_wr;
`endif
      end else begin
        rd_s = mem_r[ra_s];
      end
    end
  end

endmodule
